// File: rtl/bsg_locking_arb_rr_pkg.sv
// Shared types for the locking round-robin arbiter.
package bsg_locking_arb_rr_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } bsg_locking_arb_state_e;

endpackage

// File: rtl/bsg_locking_arb_rr_pe.sv
// Rotating-priority encoder: first request at or above ptr_i, wrapping to 0.
// Masked requesters lose unless nobody else is asking.
module bsg_locking_arb_rr_pe #(
  parameter int inputs_p = 16,
  parameter int rr_p     = 1
) (
  input  logic [inputs_p-1:0]         reqs_i,
  input  logic [$clog2(inputs_p)-1:0] ptr_i,
  input  logic [inputs_p-1:0]         excl_i,
  output logic [inputs_p-1:0]         grant_o,
  output logic                        v_o
);

  logic [inputs_p-1:0]         masked;
  logic [inputs_p-1:0]         cand;
  logic [$clog2(inputs_p)-1:0] ptr_eff;
  logic                        found;

  assign masked  = reqs_i & ~excl_i;
  assign cand    = (|masked) ? masked : reqs_i;
  assign v_o     = |cand;
  // A zero pointer turns the two-pass scan into a plain lo-to-hi encoder.
  assign ptr_eff = (rr_p != 0) ? ptr_i : '0;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int j = 0; j < inputs_p; j++) begin
      if (!found && cand[j] && (j >= int'(ptr_eff))) begin
        grant_o[j] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int j = 0; j < inputs_p; j++) begin
      if (!found && cand[j]) begin
        grant_o[j] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_locking_arb_rr.sv
// Locking arbiter: a winner keeps the grant until unlock_i or a beat-count limit,
// then priority rotates past it (or, with fixed priority, it is skipped once).
module bsg_locking_arb_rr
  import bsg_locking_arb_rr_pkg::*;
#(
  parameter int inputs_p   = 16,
  parameter int rr_p       = 1,
  parameter int max_hold_p = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        ready_i,
  input  logic [inputs_p-1:0]         reqs_i,
  input  logic                        unlock_i,
  output logic [inputs_p-1:0]         grants_o,
  output logic                        locked_o,
  output logic [$clog2(inputs_p)-1:0] owner_id_o
);

  localparam int id_w_lp     = $clog2(inputs_p);
  localparam int hold_w_lp   = (max_hold_p > 0) ? $clog2(max_hold_p + 1) : 8;
  localparam int hold_sat_lp = (max_hold_p > 0) ? max_hold_p : 255;

  bsg_locking_arb_state_e state_r;
  logic [id_w_lp-1:0]     rr_ptr_r;
  logic [hold_w_lp-1:0]   hold_cnt_r;
  logic [hold_w_lp-1:0]   hold_nxt;
  logic                   excl_r;
  logic                   hit_max;
  logic                   beat;
  logic [inputs_p-1:0]    owner_oh;
  logic [inputs_p-1:0]    pe_grant;
  logic                   pe_v;
  logic [id_w_lp-1:0]     win_id;

  function automatic logic [id_w_lp-1:0] ptr_after(input logic [id_w_lp-1:0] id);
    return (int'(id) == inputs_p - 1) ? '0 : id + 1'b1;
  endfunction

  assign locked_o = (state_r == LOCKED);

  always_comb begin
    owner_oh             = '0;
    owner_oh[owner_id_o] = 1'b1;
  end

  bsg_locking_arb_rr_pe #(
    .inputs_p(inputs_p),
    .rr_p    (rr_p)
  ) u_pe (
    .reqs_i (reqs_i),
    .ptr_i  (rr_ptr_r),
    .excl_i (excl_r ? owner_oh : '0),
    .grant_o(pe_grant),
    .v_o    (pe_v)
  );

  always_comb begin
    grants_o = '0;
    if (reset_n_i && ready_i) begin
      if (state_r == LOCKED) grants_o = owner_oh & reqs_i;
      else if (pe_v)         grants_o = pe_grant;
    end
  end

  assign beat = |grants_o;

  always_comb begin
    win_id = '0;
    for (int i = 0; i < inputs_p; i++) begin
      if (pe_grant[i]) win_id = id_w_lp'(i);
    end
  end

  always_comb begin
    hold_nxt = hold_cnt_r;
    if (hold_cnt_r != hold_w_lp'(hold_sat_lp)) hold_nxt = hold_cnt_r + 1'b1;
    hit_max = (max_hold_p > 0) && (hold_nxt == hold_w_lp'(hold_sat_lp));
  end

  // A release without unlock_i is a forced one; only fixed priority needs the skip mask.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      rr_ptr_r   <= '0;
      hold_cnt_r <= '0;
      owner_id_o <= '0;
      excl_r     <= 1'b0;
    end else begin
      unique case (state_r)
        IDLE: begin
          if (beat) begin
            owner_id_o <= win_id;
            if (unlock_i || (max_hold_p == 1)) begin
              rr_ptr_r <= ptr_after(win_id);
              excl_r   <= !unlock_i && (rr_p == 0);
            end else begin
              state_r    <= LOCKED;
              hold_cnt_r <= hold_w_lp'(1);
              excl_r     <= 1'b0;
            end
          end
        end
        LOCKED: begin
          if (beat) hold_cnt_r <= hold_nxt;
          if (unlock_i || (beat && hit_max)) begin
            state_r  <= IDLE;
            rr_ptr_r <= ptr_after(owner_id_o);
            excl_r   <= !unlock_i && (rr_p == 0);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_locking_arb_rr.sv
// Directed-vector bench for bsg_locking_arb_rr: round-robin/unbounded and fixed/max-hold-3 instances.
module tb_bsg_locking_arb_rr;

  logic       clk;
  logic       rst_n;
  logic       ready;
  logic       unlock;
  logic [3:0] reqs;
  logic [3:0] gnt_a, gnt_b;
  logic       locked_a, locked_b;
  logic [1:0] owner_a, owner_b;

  int vectors;
  int miscompares;

  bsg_locking_arb_rr #(.inputs_p(4), .rr_p(1), .max_hold_p(0)) u_a (
    .clk_i(clk), .reset_n_i(rst_n), .ready_i(ready), .reqs_i(reqs),
    .unlock_i(unlock), .grants_o(gnt_a), .locked_o(locked_a), .owner_id_o(owner_a)
  );

  bsg_locking_arb_rr #(.inputs_p(4), .rr_p(0), .max_hold_p(3)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .ready_i(ready), .reqs_i(reqs),
    .unlock_i(unlock), .grants_o(gnt_b), .locked_o(locked_b), .owner_id_o(owner_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       inst;
    logic       rst_n;
    logic       ready;
    logic       unlock;
    logic [3:0] reqs;
    logic [3:0] gnt;
    logic       chk_reg;
    logic       locked;
    int         owner;
    int         ptr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic inst, input logic r, input logic rdy, input logic unl,
                             input logic [3:0] rq, input logic [3:0] g, input logic cr,
                             input logic lk, input int own, input int ptr);
    vec_t t;
    t.inst = inst; t.rst_n = r; t.ready = rdy; t.unlock = unl; t.reqs = rq; t.gnt = g;
    t.chk_reg = cr; t.locked = lk; t.owner = own; t.ptr = ptr;
    return t;
  endfunction

  task automatic apply(input logic r, input logic rdy, input logic unl, input logic [3:0] rq);
    @(negedge clk);
    rst_n = r; ready = rdy; unlock = unl; reqs = rq;
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  int waitc[4];
  int onehot_bad, subset_bad, starve_bad;
  int h0;

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; ready = 1'b1; unlock = 1'b0; reqs = '0;

    // inst 0: rr_p=1, max_hold_p=0
    tbl.push_back(v(0, 0, 1, 0, 4'b1010, 4'b0000, 0, 0, 0, -1));
    tbl.push_back(v(0, 0, 1, 0, 4'b1010, 4'b0000, 1, 0, 0,  0));
    tbl.push_back(v(0, 1, 1, 0, 4'b1010, 4'b0010, 1, 0, 0, -1));
    tbl.push_back(v(0, 1, 1, 0, 4'b1010, 4'b0010, 1, 1, 1, -1));
    tbl.push_back(v(0, 1, 1, 1, 4'b1010, 4'b0010, 1, 1, 1, -1));
    tbl.push_back(v(0, 1, 1, 0, 4'b1010, 4'b1000, 1, 0, 1,  2));
    tbl.push_back(v(0, 1, 1, 1, 4'b1010, 4'b1000, 1, 1, 3, -1));
    tbl.push_back(v(0, 1, 1, 1, 4'b1010, 4'b0010, 1, 0, 3,  0));
    tbl.push_back(v(0, 1, 0, 0, 4'b1010, 4'b0000, 1, 0, 1,  2));
    tbl.push_back(v(0, 1, 1, 0, 4'b0101, 4'b0100, 1, 0, 1,  2));
    tbl.push_back(v(0, 1, 1, 0, 4'b0101, 4'b0100, 1, 1, 2, -1));
    tbl.push_back(v(0, 1, 0, 0, 4'b0101, 4'b0000, 1, 1, 2, -1));
    tbl.push_back(v(0, 1, 1, 0, 4'b0101, 4'b0100, 1, 1, 2, -1));
    tbl.push_back(v(0, 1, 1, 0, 4'b0001, 4'b0000, 1, 1, 2, -1));
    tbl.push_back(v(0, 1, 0, 1, 4'b0001, 4'b0000, 1, 1, 2, -1));
    tbl.push_back(v(0, 1, 1, 0, 4'b0001, 4'b0001, 1, 0, 2,  3));
    tbl.push_back(v(0, 0, 1, 0, 4'b0001, 4'b0000, 1, 1, 0, -1));
    tbl.push_back(v(0, 1, 1, 0, 4'b0000, 4'b0000, 1, 0, 0,  0));
    tbl.push_back(v(0, 1, 1, 1, 4'b1111, 4'b0001, 1, 0, 0,  0));
    tbl.push_back(v(0, 1, 1, 1, 4'b0000, 4'b0000, 1, 0, 0,  1));
    tbl.push_back(v(0, 1, 1, 0, 4'b1111, 4'b0010, 1, 0, 0,  1));
    // inst 1: rr_p=0, max_hold_p=3
    tbl.push_back(v(1, 0, 1, 0, 4'b0110, 4'b0000, 0, 0, 0, -1));
    tbl.push_back(v(1, 0, 1, 0, 4'b0110, 4'b0000, 1, 0, 0, -1));
    tbl.push_back(v(1, 1, 1, 1, 4'b0110, 4'b0010, 1, 0, 0, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0110, 4'b0010, 1, 0, 1, -1));
    tbl.push_back(v(1, 1, 1, 1, 4'b0110, 4'b0010, 1, 1, 1, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0011, 4'b0001, 1, 0, 1, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0011, 4'b0001, 1, 1, 0, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0011, 4'b0001, 1, 1, 0, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0011, 4'b0010, 1, 0, 0, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0011, 4'b0010, 1, 1, 1, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0011, 4'b0010, 1, 1, 1, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0011, 4'b0001, 1, 0, 1, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0001, 4'b0001, 1, 1, 0, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0001, 4'b0001, 1, 1, 0, -1));
    tbl.push_back(v(1, 1, 1, 0, 4'b0001, 4'b0001, 1, 0, 0, -1));

    foreach (tbl[i]) begin
      apply(tbl[i].rst_n, tbl[i].ready, tbl[i].unlock, tbl[i].reqs);
      if (tbl[i].inst == 1'b0) begin
        chk("grants_a", i, int'(gnt_a), int'(tbl[i].gnt));
        if (tbl[i].chk_reg) begin
          chk("locked_a", i, int'(locked_a), int'(tbl[i].locked));
          chk("owner_a", i, int'(owner_a), tbl[i].owner);
        end
        if (tbl[i].ptr >= 0) chk("rr_ptr_a", i, int'(u_a.rr_ptr_r), tbl[i].ptr);
      end else begin
        chk("grants_b", i, int'(gnt_b), int'(tbl[i].gnt));
        if (tbl[i].chk_reg) begin
          chk("locked_b", i, int'(locked_b), int'(tbl[i].locked));
          chk("owner_b", i, int'(owner_b), tbl[i].owner);
        end
      end
    end

    // Owner 2 locked, ready toggling 1,0,1: two beats counted.
    apply(0, 1, 0, 4'b0000);
    apply(0, 1, 0, 4'b0000);
    apply(1, 1, 0, 4'b0100);
    chk("hold_lock_gnt", 0, int'(gnt_a), 4'b0100);
    apply(1, 1, 0, 4'b0100);
    h0 = int'(u_a.hold_cnt_r);
    chk("hold_start", 0, h0, 1);
    chk("hold_gnt", 1, int'(gnt_a), 4'b0100);
    apply(1, 0, 0, 4'b0100);
    chk("hold_gnt", 2, int'(gnt_a), 4'b0000);
    apply(1, 1, 0, 4'b0100);
    chk("hold_gnt", 3, int'(gnt_a), 4'b0100);
    apply(1, 0, 0, 4'b0100);
    chk("hold_adv", 0, int'(u_a.hold_cnt_r), 3);
    chk("hold_locked", 0, int'(locked_a), 1);

    // Random traffic on the round-robin instance.
    apply(0, 1, 0, 4'b0000);
    apply(0, 1, 0, 4'b0000);
    onehot_bad = 0; subset_bad = 0; starve_bad = 0;
    for (int k = 0; k < 4; k++) waitc[k] = 0;
    for (int c = 0; c < 10000; c++) begin
      apply(1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      if ((gnt_a & (gnt_a - 4'd1)) != 4'd0) onehot_bad++;
      if ((gnt_a & ~reqs) != 4'd0) subset_bad++;
      for (int k = 0; k < 4; k++) begin
        if (!reqs[k] || gnt_a[k]) waitc[k] = 0;
        else if (gnt_a != 4'd0 && !locked_a) begin
          waitc[k]++;
          if (waitc[k] > 4) starve_bad++;
        end
      end
    end
    chk("rand_onehot0", 0, onehot_bad, 0);
    chk("rand_subset", 0, subset_bad, 0);
    chk("rand_starve", 0, starve_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_locking_arb_rr.md
BSG_LOCKING_ARB_RR -- requirements
Module: bsg_locking_arb_rr

Interface
REQ-001 The block SHALL have parameter inputs_p, default 16: number of requesters, at least 2.
REQ-002 The block SHALL have parameter rr_p, default 1: 1 = round-robin priority; 0 = fixed priority, lowest index wins.
REQ-003 The block SHALL have parameter max_hold_p, default 0: 0 = lock held until unlock; N>0 = lock force-released after N granted beats.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port ready_i, input, 1 bit: downstream can accept a beat this cycle.
REQ-007 The block SHALL have port reqs_i, input, inputs_p bits: request vector.
REQ-008 The block SHALL have port unlock_i, input, 1 bit: owner's last beat; releases the lock.
REQ-009 The block SHALL have port grants_o, output, inputs_p bits: one-hot or zero grant, combinational.
REQ-010 The block SHALL have port locked_o, output, 1 bit: registered, high while in LOCKED.
REQ-011 The block SHALL have port owner_id_o, output, $clog2(inputs_p) bits: registered index of the current or last owner.

Function
REQ-012 The block SHALL implement exactly two states, IDLE and LOCKED.
REQ-013 In IDLE with ready_i=1, grants_o SHALL be one-hot on the winner of reqs_i in the same cycle (zero latency): fixed = lowest set index; rr = first set index at or above rr_ptr, wrapping from inputs_p-1 to 0.
REQ-014 A grant in IDLE with unlock_i=0 SHALL move the block to LOCKED next cycle, with owner_id_o = winner and hold_cnt = 1.
REQ-015 A grant in IDLE with unlock_i=1 is a single-beat transfer: the block SHALL stay in IDLE and update rr_ptr per REQ-018.
REQ-016 In LOCKED, grants_o SHALL equal onehot(owner) & reqs_i & ready_i; every other requester SHALL see 0.
REQ-017 In LOCKED, each granted beat SHALL increment hold_cnt, which saturates at max_hold_p.
REQ-018 Release when unlock_i=1 in LOCKED: the current-cycle grant is still issued, the next state is IDLE, and rr_ptr SHALL become (owner+1) mod inputs_p.
REQ-019 Forced release (max_hold_p>0): when a granted beat makes hold_cnt == max_hold_p, the block SHALL go to IDLE next cycle exactly as in REQ-018.
REQ-020 Forced release with rr_p=0: the previous owner SHALL be excluded from the next IDLE arbitration if any other request is set; otherwise it may win again.
REQ-021 ready_i=0: grants_o SHALL be 0, with no state change and no hold_cnt increment; unlock_i SHALL still be honoured in LOCKED.
REQ-022 unlock_i in IDLE with no grant SHALL be ignored.
REQ-023 If the owner drops its request while LOCKED, the lock SHALL be held and grants_o SHALL be 0.
REQ-024 grants_o SHALL never have more than one bit set.

Reset
REQ-025 While reset_n_i=0 at a clk_i edge, the registers SHALL load: state=IDLE, rr_ptr=0, hold_cnt=0, owner_id_o=0, locked_o=0.
REQ-026 grants_o SHALL be 0 in any cycle where reset_n_i=0.
REQ-027 Reset asserted in the middle of a LOCKED transaction SHALL abandon the lock immediately, with no release bookkeeping.

Structure
REQ-028 The state enum typedef SHALL live in the shared bsg package as bsg_locking_arb_state_e.
REQ-029 Rotating priority selection SHALL be a separate sub-module, bsg_locking_arb_rr_pe (inputs: reqs, ptr, exclude mask; outputs: one-hot, v).
REQ-030 The sub-module SHALL reduce to a plain lo-to-hi encoder when rr_p=0.

Verification
REQ-031 Setup for all scenarios: inputs_p=4, ready_i=1 unless stated.
REQ-032 rr_p=1, reqs_i=4'b1010 from reset -> grants_o=4'b0010, LOCKED with owner 1; unlock_i in cycle 3 -> next grant 4'b1000 (rr_ptr=2).
REQ-033 rr_p=0, reqs_i=4'b0110 and unlock_i=1 in the same cycle from IDLE -> grants_o=4'b0010, locked_o stays 0; next cycle grants 4'b0010 again.
REQ-034 max_hold_p=3, rr_p=0, reqs_i=4'b0011 held -> exactly 3 grants to bit 0, release, then grants_o=4'b0010 (exclusion).
REQ-035 LOCKED with owner 2 and ready_i toggling 1,0,1 -> grants_o = 4'b0100, 0, 4'b0100, and hold_cnt advances by 2.
REQ-036 reset_n_i=0 during LOCKED -> same cycle grants_o=0; next cycle locked_o=0, owner_id_o=0, rr_ptr=0.
REQ-037 Random reqs_i/ready_i/unlock_i stimulus, 10k cycles, rr_p=1 -> onehot0(grants_o) always holds, and no requester waits more than inputs_p lock tenures.
